// File: rtl/taillight_switch_decoder_if.sv
// Switch inputs and sequencer-facing outputs of the taillight switch decoder.
// The master side drives the raw switches; the slave side is the decoder.
interface taillight_switch_decoder_if;
    logic       sw_l;
    logic       sw_r;
    logic       sw_brk;
    logic       sw_err;
    logic [2:0] mode;
    logic       mode_chg;
    logic       step_tick;
    logic [3:0] sw_clean;

    modport master (
        output sw_l, sw_r, sw_brk, sw_err,
        input  mode, mode_chg, step_tick, sw_clean
    );

    modport slave (
        input  sw_l, sw_r, sw_brk, sw_err,
        output mode, mode_chg, step_tick, sw_clean
    );
endinterface

// File: rtl/taillight_switch_decoder.sv
// Taillight input front end: synchronize, debounce and priority-decode the board switches,
// then hold the mode until a pattern-step boundary (ERROR entry excepted).
module taillight_switch_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 12500000
) (
    input logic                        clk,
    input logic                        rst_n,
    taillight_switch_decoder_if.slave  bus
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TkW = $clog2(TICK_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TkW-1:0] TkLast = TkW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        ModeIdle   = 3'd0,
        ModeLeft   = 3'd1,
        ModeRight  = 3'd2,
        ModeBrake  = 3'd3,
        ModeHazard = 3'd4,
        ModeError  = 3'd5
    } mode_e;

    typedef enum logic {StHold, StPend} state_e;

    // Bit order {err, brk, r, l} throughout.
    logic [3:0]     raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     stable_q, stable_d;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];
    logic [TkW-1:0] tk_cnt_q, tk_cnt_d;
    logic           tick_now, tick_q;
    mode_e          req, mode_q, mode_d;
    state_e         state_q, state_d;
    logic           chg_q, chg_d;
    logic           err_entry;

    assign raw = {bus.sw_err, bus.sw_brk, bus.sw_r, bus.sw_l};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) stable_d[i] = sync2_q[i];
                else                       db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
    end

    always_comb begin
        if (stable_q[3])                    req = ModeError;
        else if (stable_q[0] && stable_q[1]) req = ModeHazard;
        else if (stable_q[2])               req = ModeBrake;
        else if (stable_q[0])               req = ModeLeft;
        else if (stable_q[1])               req = ModeRight;
        else                                req = ModeIdle;
    end

    assign tick_now = (tk_cnt_q == TkLast);

    // ERROR entry is held off one cycle after any strobe so mode_chg never repeats back-to-back.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        chg_d     = 1'b0;
        err_entry = 1'b0;
        unique case (state_q)
            StHold: begin
                if (req != mode_q) begin
                    if (req == ModeError) err_entry = !chg_q;
                    else                  state_d   = StPend;
                end
            end
            StPend: begin
                if (req == mode_q) begin
                    state_d = StHold;
                end else if (req == ModeError) begin
                    if (!chg_q) begin
                        err_entry = 1'b1;
                        state_d   = StHold;
                    end
                end else if (tick_now) begin
                    mode_d  = req;
                    chg_d   = 1'b1;
                    state_d = StHold;
                end
            end
            default: state_d = StHold;
        endcase
        if (err_entry) begin
            mode_d = ModeError;
            chg_d  = 1'b1;
        end
    end

    always_comb begin
        tk_cnt_d = tick_now ? '0 : tk_cnt_q + TkW'(1);
        if (err_entry) tk_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            tk_cnt_q <= '0;
            tick_q   <= 1'b0;
            mode_q   <= ModeIdle;
            chg_q    <= 1'b0;
            state_q  <= StHold;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            tk_cnt_q <= tk_cnt_d;
            tick_q   <= tick_now;
            mode_q   <= mode_d;
            chg_q    <= chg_d;
            state_q  <= state_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.mode_chg  = chg_q;
    assign bus.step_tick = tick_q;
    assign bus.sw_clean  = stable_q;

endmodule
